// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder family.
// Holds the FSM state encoding, the add/subtract opcode values and a
// constant-foldable ceil(log2) helper used to size digit counters.
package adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for digit_serial_adder.
// Ports: in_valid/in_ready/a/b/c_in (+op when ADDER_SUB_EN) from producer,
//        out_valid/out_ready/sum/c_out towards consumer.
interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef ADDER_SUB_EN
  logic             op;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;

`ifdef ADDER_SUB_EN
  modport master (
    output in_valid, a, b, c_in, op, out_ready,
    input  in_ready, out_valid, sum, c_out
  );
  modport slave (
    input  in_valid, a, b, c_in, op, out_ready,
    output in_ready, out_valid, sum, c_out
  );
`else
  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
  );
  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
  );
`endif

endinterface

// File: rtl/digit_add.sv
// DIGIT-bit combinational adder with carry in and carry out.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; no state, no handshake.
// Ports: a, b (DIGIT bits), ci -> s (DIGIT bits), co.
module digit_add #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] total;

  assign total   = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
  assign {co, s} = total;

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle WIDTH-bit adder that processes DIGIT bits per clock, LSB digit first.
// Latency: N = WIDTH/DIGIT cycles from accept to out_valid; one result per N+2 cycles.
// Backpressure: result is held in DONE until out_ready; in_ready is low outside IDLE.
// Ports: clk, rst (sync, active-high), io (slave side of digit_serial_adder_if), busy.
// Optional feature: define ADDER_SUB_EN to add the op port and subtract mode.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  digit_serial_adder_if.slave   io,
  output logic                  busy
);

  localparam int              N    = WIDTH / DIGIT;
  localparam int              CW   = (clog2(N) < 1) ? 1 : clog2(N);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [DIGIT-1:0] dsum;
  logic             dcarry;
  logic             accept;

`ifdef ADDER_SUB_EN
  logic             sub_sel;
  logic             sub_q;

  assign sub_sel = (io.op == OP_SUB);
`endif

  // in_ready_q is low in the first cycle after reset even though state is
  // already IDLE, so it must gate the accept as well.
  assign accept = (state == IDLE) && in_ready_q && io.in_valid;

  // ---------------------------------------------------------------------
  // FSM: state and registered handshake outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt == IDLE);
      out_valid_q <= (state_nxt == DONE);
      busy_q      <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    if (io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: one digit adder, operands shift right, sum fills from the top
  // ---------------------------------------------------------------------
  digit_add #(.DIGIT(DIGIT)) u_digit_add (
    .a  (a_sr[DIGIT-1:0]),
    .b  (b_sr[DIGIT-1:0]),
    .ci (carry),
    .s  (dsum),
    .co (dcarry)
  );

  // After N shifts the first digit computed has reached the LSB end.
  generate
    if (N == 1) begin : g_single
      assign sum_nxt = dsum;
    end else begin : g_multi
      assign sum_nxt = {dsum, sum_sr[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
`ifdef ADDER_SUB_EN
      sub_q  <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= io.a;
`ifdef ADDER_SUB_EN
      // a - b - c_in == a + ~b + !c_in
      b_sr  <= sub_sel ? ~io.b : io.b;
      carry <= io.c_in ^ sub_sel;
      sub_q <= sub_sel;
`else
      b_sr  <= io.b;
      carry <= io.c_in;
`endif
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> DIGIT;
      b_sr   <= b_sr >> DIGIT;
      sum_sr <= sum_nxt;
      carry  <= dcarry;
      cnt    <= cnt + CW'(1);
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.sum       = sum_sr;
  assign busy         = busy_q;

`ifdef ADDER_SUB_EN
  // In subtract mode the final carry is the inverse of the borrow.
  assign io.c_out = carry ^ sub_q;
`else
  assign io.c_out = carry;
`endif

endmodule
